// File: rtl/if_id_hazard_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | if_id_hazard_ctrl_if : IF/ID sequencing controller signal bundle      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface if_id_hazard_ctrl_if;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1_ind;
  logic [4:0]  id_rs2_ind;
  logic        ex_memread;
  logic [4:0]  ex_rd_ind;
  logic        branch_taken;
  logic        exception;
  logic        imem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_flush;
  logic        id_ex_bubble;
  logic [2:0]  ctrl_state;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // master: the pipeline side; slave: the controller
  modport master (
    output id_opcode, id_rs1_ind, id_rs2_ind, ex_memread, ex_rd_ind,
           branch_taken, exception, imem_ready,
    input  pc_write, if_id_write, if_flush, id_ex_bubble, ctrl_state,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_opcode, id_rs1_ind, id_rs2_ind, ex_memread, ex_rd_ind,
           branch_taken, exception, imem_ready,
    output pc_write, if_id_write, if_flush, id_ex_bubble, ctrl_state,
           stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/if_id_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | if_id_hazard_ctrl : PC / IF/ID sequencing (stall, flush, wait, halt)  |
// | Optional perf counters: HAZARD_PERF_CNT_EN.   Rev 1.0                 |
// +-----------------------------------------------------------------------+
module if_id_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter logic [6:0]  HALT_OPCODE       = 7'b1111111
) (
  input  logic              clk,
  input  logic              rst,
  if_id_hazard_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_LOAD_STALL = 3'd1,
    ST_FLUSH      = 3'd2,
    ST_IMEM_WAIT  = 3'd3,
    ST_HALT       = 3'd4
  } state_t;

  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam state_t     STALL_ENTRY  = (LOAD_STALL_CYCLES > 1) ? ST_LOAD_STALL : ST_RUN;
  localparam state_t     FLUSH_ENTRY  = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic hz;
  logic redirect;
  logic halt_op;
  logic pc_write;
  logic if_id_write;
  logic if_flush;
  logic id_ex_bubble;

  assign hz = bus.ex_memread && (bus.ex_rd_ind != 5'd0) &&
              ((bus.ex_rd_ind == bus.id_rs1_ind) || (bus.ex_rd_ind == bus.id_rs2_ind));
  assign redirect = bus.exception || bus.branch_taken;
  assign halt_op  = (bus.id_opcode == HALT_OPCODE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_flush     = 1'b0;
    id_ex_bubble = 1'b0;

    case (state_q)
      ST_RUN, ST_IMEM_WAIT: begin
        if (redirect) begin
          if_flush     = 1'b1;
          id_ex_bubble = bus.exception;
          state_d      = FLUSH_ENTRY;
          cnt_d        = FLUSH_RELOAD;
        end else if (!bus.imem_ready) begin
          pc_write = 1'b0;
          if_flush = 1'b1;
          state_d  = ST_IMEM_WAIT;
        end else if (hz) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          // Returning from a fetch wait goes straight back to RUN.
          if (state_q == ST_RUN) begin
            state_d = STALL_ENTRY;
            cnt_d   = STALL_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (halt_op) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          state_d     = (state_q == ST_RUN) ? ST_HALT : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_LOAD_STALL: begin
        if (redirect) begin
          if_flush     = 1'b1;
          id_ex_bubble = bus.exception;
          state_d      = FLUSH_ENTRY;
          cnt_d        = FLUSH_RELOAD;
        end else begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      ST_FLUSH: begin
        if_flush     = 1'b1;
        id_ex_bubble = 1'b1;
        if (redirect) begin
          state_d = FLUSH_ENTRY;
          cnt_d   = FLUSH_RELOAD;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_HALT: begin
        if (bus.exception) begin
          if_flush     = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = FLUSH_ENTRY;
          cnt_d        = FLUSH_RELOAD;
        end else begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_flush     = if_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.ctrl_state   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_ex_bubble && !if_flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (if_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_if_id_hazard_ctrl : scoreboard bench for two controller configs    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_if_id_hazard_ctrl;

  typedef struct {
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       memread;
    logic [4:0] rd;
    logic       br;
    logic       exc;
    logic       ready;
  } stim_t;

  typedef struct {
    logic [3:0]  outs;   // {pc_write, if_id_write, if_flush, id_ex_bubble}
    logic [2:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_id_hazard_ctrl_if bus_a ();
  if_id_hazard_ctrl_if bus_b ();

  if_id_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(1), .HALT_OPCODE(7'h7F)) u_dut_a (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_a)
  );

  if_id_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .HALT_OPCODE(7'h7F)) u_dut_b (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t q0[$];
  exp_t q1[$];

  // Reference model: remaining cycles of each activity, not a state register.
  int          ls_cfg [2] = '{2, 3};
  int          fc_cfg [2] = '{1, 2};
  int          stall_left [2];
  int          flush_left [2];
  bit          waiting [2];
  bit          halted [2];
  logic [31:0] m_scnt [2];
  logic [31:0] m_fcnt [2];

  task automatic model_reset(input int i);
    stall_left[i] = 0;
    flush_left[i] = 0;
    waiting[i]    = 1'b0;
    halted[i]     = 1'b0;
    m_scnt[i]     = 32'd0;
    m_fcnt[i]     = 32'd0;
  endtask

  task automatic model_step(input int i, input stim_t s, output exp_t e);
    bit hz, redirect;
    logic [3:0] o;
    hz = s.memread && (s.rd != 0) && ((s.rd == s.rs1) || (s.rd == s.rs2));
    redirect = s.exc || s.br;
    e.st  = (flush_left[i] > 0) ? 3'd2 : halted[i] ? 3'd4 :
            (stall_left[i] > 0) ? 3'd1 : waiting[i] ? 3'd3 : 3'd0;
`ifdef HAZARD_PERF_CNT_EN
    e.sc = m_scnt[i];
    e.fc = m_fcnt[i];
`else
    e.sc = 32'd0;
    e.fc = 32'd0;
`endif
    e.cyc = cyc;
    if (flush_left[i] > 0) begin
      o = 4'b1111;
      flush_left[i] = redirect ? fc_cfg[i] - 1 : flush_left[i] - 1;
    end else if (halted[i]) begin
      if (s.exc) begin
        o = 4'b1111;
        halted[i] = 1'b0;
        flush_left[i] = fc_cfg[i] - 1;
      end else begin
        o = 4'b0001;
      end
    end else if (stall_left[i] > 0) begin
      if (redirect) begin
        o = {3'b111, s.exc};
        stall_left[i] = 0;
        flush_left[i] = fc_cfg[i] - 1;
      end else begin
        o = 4'b0001;
        stall_left[i] = stall_left[i] - 1;
      end
    end else begin
      if (redirect) begin
        o = {3'b111, s.exc};
        flush_left[i] = fc_cfg[i] - 1;
        waiting[i] = 1'b0;
      end else if (!s.ready) begin
        o = 4'b0110;
        waiting[i] = 1'b1;
      end else if (hz) begin
        o = 4'b0001;
        if (!waiting[i]) stall_left[i] = ls_cfg[i] - 1;
        waiting[i] = 1'b0;
      end else if (s.opcode == 7'h7F) begin
        o = 4'b0000;
        if (!waiting[i]) halted[i] = 1'b1;
        waiting[i] = 1'b0;
      end else begin
        o = 4'b1100;
        waiting[i] = 1'b0;
      end
    end
    e.outs = o;
    if (o[0] && !o[1]) m_scnt[i] = m_scnt[i] + 32'd1;
    if (o[1])          m_fcnt[i] = m_fcnt[i] + 32'd1;
  endtask

  task automatic drive(input stim_t s);
    bus_a.id_opcode = s.opcode;  bus_b.id_opcode = s.opcode;
    bus_a.id_rs1_ind = s.rs1;    bus_b.id_rs1_ind = s.rs1;
    bus_a.id_rs2_ind = s.rs2;    bus_b.id_rs2_ind = s.rs2;
    bus_a.ex_memread = s.memread; bus_b.ex_memread = s.memread;
    bus_a.ex_rd_ind = s.rd;      bus_b.ex_rd_ind = s.rd;
    bus_a.branch_taken = s.br;   bus_b.branch_taken = s.br;
    bus_a.exception = s.exc;     bus_b.exception = s.exc;
    bus_a.imem_ready = s.ready;  bus_b.imem_ready = s.ready;
  endtask

  // One cycle: change inputs just after the edge, log the expected response.
  task automatic cycle(input stim_t s, input logic rst_val);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst_val;
    drive(s);
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_val) model_reset(i);
      model_step(i, s, e);
      if (!rst_val) model_reset(i);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic check(input int i, input exp_t e, input logic [3:0] o, input logic [2:0] st,
                       input logic [31:0] sc, input logic [31:0] fc);
    n_tests = n_tests + 1;
    if (o !== e.outs || st !== e.st || sc !== e.sc || fc !== e.fc) begin
      n_fail = n_fail + 1;
      $display("FAIL dut%0d cycle %0d: got outs=%b state=%0d stall_cnt=%0d flush_cnt=%0d, required outs=%b state=%0d stall_cnt=%0d flush_cnt=%0d",
               i, e.cyc, o, st, sc, fc, e.outs, e.st, e.sc, e.fc);
    end
  endtask

  // Monitor: every cycle the DUTs present outputs; compare at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check(0, e, {bus_a.pc_write, bus_a.if_id_write, bus_a.if_flush, bus_a.id_ex_bubble},
              bus_a.ctrl_state, bus_a.stall_cnt, bus_a.flush_cnt);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check(1, e, {bus_b.pc_write, bus_b.if_id_write, bus_b.if_flush, bus_b.id_ex_bubble},
              bus_b.ctrl_state, bus_b.stall_cnt, bus_b.flush_cnt);
      end
    end
  end

  initial begin
    stim_t idle, s;
    int    waits;
    idle = '{opcode: 7'h00, rs1: 5'd1, rs2: 5'd2, memread: 1'b0, rd: 5'd0,
             br: 1'b0, exc: 1'b0, ready: 1'b1};
    drive(idle);
    model_reset(0);
    model_reset(1);

    // Reset state
    repeat (2) cycle(idle, 1'b0);
    repeat (2) cycle(idle, 1'b1);

    // Load-use on rs2
    s = idle; s.memread = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5;
    cycle(s, 1'b1);
    repeat (4) cycle(idle, 1'b1);

    // Load to x0 never stalls
    s = idle; s.memread = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0;
    repeat (2) cycle(s, 1'b1);

    // Branch together with a hazard: flush wins
    s = idle; s.memread = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.br = 1'b1;
    cycle(s, 1'b1);
    repeat (3) cycle(idle, 1'b1);

    // Instruction memory wait
    s = idle; s.ready = 1'b0;
    repeat (3) cycle(s, 1'b1);
    repeat (2) cycle(idle, 1'b1);

    // Halt, then exception releases it through FLUSH
    s = idle; s.opcode = 7'h7F;
    cycle(s, 1'b1);
    repeat (10) cycle(s, 1'b1);
    s.exc = 1'b1;
    cycle(s, 1'b1);
    repeat (3) cycle(idle, 1'b1);

    // Reset in the middle of a load stall
    s = idle; s.memread = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7;
    cycle(s, 1'b1);
    cycle(idle, 1'b1);
    cycle(idle, 1'b0);
    repeat (2) cycle(idle, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      s.opcode  = ($urandom_range(0, 29) == 0) ? 7'h7F : 7'($urandom_range(0, 126));
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 3));
      s.memread = 1'($urandom_range(0, 1));
      s.br      = ($urandom_range(0, 7) == 0);
      s.exc     = ($urandom_range(0, 15) == 0);
      s.ready   = ($urandom_range(0, 5) != 0);
      cycle(s, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end
    cycle(idle, 1'b1);

    waits = 0;
    while ((q0.size() > 0 || q1.size() > 0) && waits < 10) begin
      @(posedge clk);
      waits = waits + 1;
    end
    @(posedge clk);
    n_tests = n_tests + 1;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
